// File: rtl/seq_hazard_forwarding_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: regfile select code and
// the bit layout of one tag-pipeline entry {addr, is_load, valid}.
package seq_hazard_forwarding_unit_pkg;

  localparam int FWD_SEL_REGFILE = 0;

  localparam int TAG_VALID_BIT = 0;
  localparam int TAG_LOAD_BIT  = 1;
  localparam int TAG_ADDR_LSB  = 2;

  function automatic int tagWidth(input int addrWidth);
    return addrWidth + TAG_ADDR_LSB;
  endfunction

endpackage

// File: rtl/comb_forward_select.sv
// Priority match of one source operand against every tracked tag entry;
// the youngest (lowest-numbered) matching stage wins.
module comb_forward_select
  import seq_hazard_forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int FWD_DEPTH      = 2,
  parameter int SEL_W          = 2
) (
  input  logic                                            src_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]                       src_addr_i,
  input  logic [FWD_DEPTH*tagWidth(REG_ADDR_WIDTH)-1:0]   entries_i,
  output logic [SEL_W-1:0]                                sel_o,
  output logic                                            load_hazard_o
);

  localparam int TAG_W = tagWidth(REG_ADDR_WIDTH);

  logic [SEL_W-1:0] winner;
  logic             winnerIsLoad;

  // Scan oldest to youngest so the last hit written is the youngest entry.
  always_comb begin
    winner       = SEL_W'(FWD_SEL_REGFILE);
    winnerIsLoad = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (src_valid_i && entries_i[(k-1)*TAG_W + TAG_VALID_BIT] &&
          (entries_i[(k-1)*TAG_W + TAG_ADDR_LSB +: REG_ADDR_WIDTH] == src_addr_i)) begin
        winner       = SEL_W'(k);
        winnerIsLoad = entries_i[(k-1)*TAG_W + TAG_LOAD_BIT];
      end
    end
  end

  // A load result only exists in the last tracked stage; earlier means wait.
  always_comb begin
    load_hazard_o = winnerIsLoad && (winner != SEL_W'(FWD_DEPTH));
    sel_o         = load_hazard_o ? SEL_W'(FWD_SEL_REGFILE) : winner;
  end

endmodule

// File: rtl/seq_hazard_forwarding_unit.sv
// Operand forwarding / load-use stall unit tracking FWD_DEPTH stages past READ.
// Optional statistics counters are enabled with the macro HAZARD_STATS_EN.
module seq_hazard_forwarding_unit
  import seq_hazard_forwarding_unit_pkg::*;
#(
  parameter  int REG_ADDR_WIDTH = 3,
  parameter  int NUM_OPERANDS   = 2,
  parameter  int FWD_DEPTH      = 2,
  localparam int SEL_W          = $clog2(FWD_DEPTH + 1)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_advance,
  input  logic                                   i_flush,
  input  logic [NUM_OPERANDS-1:0]                i_src_valid,
  input  logic [NUM_OPERANDS*REG_ADDR_WIDTH-1:0] i_src_addr,
  input  logic                                   i_dst_valid,
  input  logic [REG_ADDR_WIDTH-1:0]              i_dst_addr,
  input  logic                                   i_dst_is_load,
  output logic [NUM_OPERANDS*SEL_W-1:0]          o_fwd_sel,
  output logic                                   o_stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]                            o_stall_cycles,
  output logic [15:0]                            o_fwd_events
`endif
);

  localparam int TAG_W = tagWidth(REG_ADDR_WIDTH);

  logic [FWD_DEPTH-1:0][TAG_W-1:0] tagPipe_q, tagPipe_d;
  logic [FWD_DEPTH*TAG_W-1:0]      tagFlat;
  logic [NUM_OPERANDS-1:0]         loadHazard;

  assign tagFlat = tagPipe_q;

  for (genvar j = 0; j < NUM_OPERANDS; j++) begin : g_operand
    comb_forward_select #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .FWD_DEPTH     (FWD_DEPTH),
      .SEL_W         (SEL_W)
    ) u_select (
      .src_valid_i  (i_src_valid[j]),
      .src_addr_i   (i_src_addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .entries_i    (tagFlat),
      .sel_o        (o_fwd_sel[j*SEL_W +: SEL_W]),
      .load_hazard_o(loadHazard[j])
    );
  end

  assign o_stall = (|loadHazard) && !i_flush;

  // A stalled advance lets older entries drain while a bubble enters stage 1.
  always_comb begin
    tagPipe_d = tagPipe_q;
    if (i_flush) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        tagPipe_d[k][TAG_VALID_BIT] = 1'b0;
      end
    end else if (i_advance) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        tagPipe_d[k] = tagPipe_q[k-1];
      end
      tagPipe_d[0] = '0;
      if (!o_stall) begin
        tagPipe_d[0][TAG_VALID_BIT]                       = i_dst_valid;
        tagPipe_d[0][TAG_LOAD_BIT]                        = i_dst_is_load;
        tagPipe_d[0][TAG_ADDR_LSB +: REG_ADDR_WIDTH]      = i_dst_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tagPipe_q <= '0;
    end else begin
      tagPipe_q <= tagPipe_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCycles_q, fwdEvents_q;

  // Saturating event counters; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stallCycles_q <= '0;
      fwdEvents_q   <= '0;
    end else begin
      if (o_stall && (stallCycles_q != 16'hFFFF)) begin
        stallCycles_q <= stallCycles_q + 16'd1;
      end
      if (i_advance && !o_stall && (|o_fwd_sel) && (fwdEvents_q != 16'hFFFF)) begin
        fwdEvents_q <= fwdEvents_q + 16'd1;
      end
    end
  end

  assign o_stall_cycles = stallCycles_q;
  assign o_fwd_events   = fwdEvents_q;
`endif

endmodule
